// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential unsigned N x N -> 2N multiplier. One shared N-bit ripple-carry
//   adder performs at most one add per cycle, so a multiply takes N CALC cycles.
//   Start/busy/done handshake with a registered product.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         request; sampled only in IDLE or DONE
//   multiplicand  operand M, latched on accept
//   multiplier    operand Q, latched on accept
//   busy          high while iterating
//   done          one-cycle completion pulse
//   product       2N-bit result; updates only on completion or reset
//
// Also contains NbitAdder, the N-bit ripple-carry adder shared by the datapath.

module NbitAdder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carryin,
    output logic [N-1:0] s,
    output logic         carryout
);
    logic [N:0] cy;

    assign cy[0] = carryin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]    = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end

    assign carryout = cy[N];
endmodule

module shift_add_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [N-1:0]  a, q, m;
    logic          c;
    logic [CW-1:0] cnt;

    logic [N-1:0]  s;
    logic          co;
    logic [N-1:0]  a_nxt, q_nxt;

    NbitAdder #(.N(N)) u_add (
        .a        (a),
        .b        (m),
        .carryin  (1'b0),
        .s        (s),
        .carryout (co)
    );

    // One iteration: optionally add M into the high half, then shift the
    // whole {C,A,Q} right by one. The carry-out lands in the top bit of A,
    // so C is always zero after the shift.
    always_comb begin
        a_nxt = {c, a[N-1:1]};
        q_nxt = {a[0], q[N-1:1]};
        if (q[0]) begin
            a_nxt = {co, s[N-1:1]};
            q_nxt = {s[0], q[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a       <= '0;
            q       <= '0;
            m       <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= multiplicand;
                        q     <= multiplier;
                        a     <= '0;
                        c     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    a   <= a_nxt;
                    q   <= q_nxt;
                    c   <= 1'b0;
                    cnt <= cnt + 1'b1;
                    // Product is taken from this cycle's shift result so done
                    // lands exactly N cycles after the accept edge.
                    if (cnt == LAST) begin
                        product <= {a_nxt, q_nxt};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned N×N→2N multiplier built around one instance of the team's N-bit ripple-carry adder (`NbitAdder`). Each iteration performs at most one addition on the shared adder, so a full multiply takes N iterations. The block is a start/busy/done controller with a registered product. It sits beside the ALU and serves multi-cycle MUL instructions.

## Interface
Parameters:
- N, 32, operand width; legal N ≥ 2. Iteration counter width is $clog2(N)+1.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- multiplicand  in  N  operand M; latched when start is accepted.
- multiplier  in  N  operand Q; latched when start is accepted.
- busy  out  N/A, 1 bit  high while in CALC.
- done  out  1  single-cycle pulse on completion.
- product  out  2N  result register; changes only on completion or reset.

## Operation
- Internal registers:
  - A[N-1:0], accumulator high half.
  - Q[N-1:0], multiplier / low half.
  - M[N-1:0], multiplicand.
  - C, adder carry-out.
  - cnt, iteration counter.
- Adder instance wiring:
  - A-input = A, B-input = M, carryin = 0.
  - Outputs are sum S[N-1:0] and carryout co.
- States: IDLE, CALC, DONE.
- **IDLE / DONE with start=1:** M←multiplicand, Q←multiplier, A←0, C←0, cnt←0; go to CALC.
- **IDLE with start=0:** hold state.
- **DONE with start=0:** go to IDLE.
- **CALC, each cycle:**
  - If Q[0]=1: {C,A,Q} ← {co, S, Q} >> 1, i.e. A←{co,S[N-1:1]}, Q←{S[0],Q[N-1:1]}.
  - If Q[0]=0: A←{0,A[N-1:1]}, Q←{A[0],Q[N-1:1]}.
  - cnt←cnt+1.
  - On the iteration where cnt=N-1: product←final {A,Q} (computed from this cycle's shift); go to DONE.
- Arithmetic is unsigned; the result is exact, with no truncation. The top bit comes from the adder carry-out.
- start asserted while in CALC is ignored; the operand inputs are don't-care then.
- Operand inputs are not required to be held after the accept edge.

## Timing
- **Reset** (rst_n=0 at a rising edge):
  - State = IDLE, busy=0, done=0, product=0.
  - A, Q, M, C and cnt are all cleared.
  - Reset overrides start.
  - Reset mid-CALC aborts the operation with no done pulse; product reads 0 after that edge.
- **Accept edge E0** (start=1 in IDLE/DONE): busy=1 from the cycle after E0.
- **Iterations:** edges E1…EN perform iterations 0…N-1.
- **After EN:**
  - busy=0, done=1, product valid.
  - Latency from the accept edge to done is exactly N cycles.
- **After EN+1:** done=0.
  - A start sampled at EN+1 (state DONE) is accepted, so back-to-back throughput is one result per N+1 cycles.
- **product holding:** product keeps its previous value through the next operation's whole CALC phase. It updates only at that operation's EN.
- done is never asserted for two consecutive cycles.
- busy and done are never asserted together.

## Test plan
- **Basic multiply:** N=8; reset, then start with 3×5.
  - busy high for exactly 8 cycles.
  - done pulses 8 cycles after the accept edge.
  - product = 15 (0x000F).
- **Carry path:** N=8; 255×255 → product = 65025 (0xFE01).
  - N=32; 0xFFFFFFFF×0xFFFFFFFF → product = 0xFFFFFFFE_00000001.
- **Zero / identity:** N=8.
  - 0×200 → 0.
  - 200×1 → 200.
  - 1×200 → 200.
  - Every case takes 8 cycles; there is no early termination.
- **Start during busy:** N=8; 6×7 accepted, then start=1 with 9×9 held for the whole CALC phase.
  - Result 42.
  - At the DONE cycle the still-high start is accepted: 9×9=81 follows 9 cycles after the first done.
  - product stays 42 until that point.
- **Reset mid-operation:** N=8; start 10×10, assert rst_n=0 on the 4th CALC cycle.
  - The next edge gives busy=0, done=0, product=0, with no done pulse.
  - A subsequent 10×10 returns 100.
- **Random regression:** N=8 and N=32; 1000 random operand pairs with random start gaps, including zero-gap back-to-back runs.
  - product must equal a reference model.
  - done count must equal accepted-start count.
